// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Summary  : Fetch-stage BTB + saturating-counter BHT next-PC predictor,
//            trained by resolved control transfers from ID; optional gshare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
    parameter int PC_W   = 30,
    parameter int IDX_W  = 6,
    parameter int CTR_W  = 2,
    parameter int GSHARE = 0,
    parameter int GHR_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // fetch-side lookup
    input  logic              if_valid,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic [IDX_W-1:0]  pred_idx,
    // resolve-side training
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic [IDX_W-1:0]  upd_idx,
    input  logic              upd_is_cond,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_mispredict,
    output logic [PERF_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;

    localparam logic [CTR_W-1:0]  c_CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0]  c_CTR_MAX  = '1;
    localparam logic [PERF_W-1:0] c_CNT_MAX  = '1;

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic              r_btb_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_btb_tag    [ENTRIES];
    logic [PC_W-1:0]   r_btb_target [ENTRIES];
    logic              r_btb_cond   [ENTRIES];
    logic [CTR_W-1:0]  r_bht        [ENTRIES];
    logic [GHR_W-1:0]  r_ghr;
    logic [PERF_W-1:0] r_mispred_cnt;

    // ------------------------------------------------------------------
    // Lookup path (purely combinational from registered state)
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_if_low;
    logic [TAG_W-1:0] w_if_tag;
    logic [IDX_W-1:0] w_bht_idx;
    logic [CTR_W-1:0] w_look_ctr;
    logic             w_hit;
    logic             w_pred_taken;

    assign w_if_low = if_pc[IDX_W-1:0];
    assign w_if_tag = if_pc[PC_W-1:IDX_W];

    generate
        if (GSHARE != 0) begin : g_gshare
            assign w_bht_idx = w_if_low ^ IDX_W'(r_ghr);
        end else begin : g_bimodal
            assign w_bht_idx = w_if_low;
        end
    endgenerate

    assign w_look_ctr = r_bht[w_bht_idx];
    assign w_hit      = r_btb_valid[w_if_low] && (r_btb_tag[w_if_low] == w_if_tag);

    // Jumps always redirect on a hit; branches only when the counter MSB says taken.
    assign w_pred_taken = if_valid && !rst && w_hit
                          && (!r_btb_cond[w_if_low] || w_look_ctr[CTR_W-1]);

    assign pred_taken  = w_pred_taken;
    assign pred_target = w_pred_taken ? r_btb_target[w_if_low] : (if_pc + PC_W'(1));
    assign pred_idx    = w_bht_idx;
    assign mispred_cnt = r_mispred_cnt;

    // ------------------------------------------------------------------
    // Update path
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_upd_low;
    logic [CTR_W-1:0] w_upd_ctr;
    logic [CTR_W-1:0] w_ctr_next;
    logic [GHR_W-1:0] w_ghr_next;
    logic             w_upd_en;

    assign w_upd_low = upd_pc[IDX_W-1:0];
    assign w_upd_ctr = r_bht[upd_idx];
    assign w_upd_en  = upd_valid && !rst;

    always_comb begin
        w_ctr_next = w_upd_ctr;
        if (upd_taken) begin
            if (w_upd_ctr != c_CTR_MAX) begin
                w_ctr_next = w_upd_ctr + CTR_W'(1);
            end
        end else if (w_upd_ctr != '0) begin
            w_ctr_next = w_upd_ctr - CTR_W'(1);
        end
    end

    generate
        if (GHR_W > 1) begin : g_ghr_shift
            assign w_ghr_next = {r_ghr[GHR_W-2:0], upd_taken};
        end else begin : g_ghr_bit
            assign w_ghr_next = upd_taken;
        end
    endgenerate

    // Control state: valid bits, counters, history and perf counter are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb_valid[i] <= 1'b0;
                r_bht[i]       <= c_CTR_INIT;
            end
            r_ghr         <= '0;
            r_mispred_cnt <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                r_btb_valid[w_upd_low] <= 1'b1;
            end
            if (upd_is_cond) begin
                r_bht[upd_idx] <= w_ctr_next;
                r_ghr          <= w_ghr_next;
            end
            if (upd_mispredict && (r_mispred_cnt != c_CNT_MAX)) begin
                r_mispred_cnt <= r_mispred_cnt + PERF_W'(1);
            end
        end
    end

    // Payload fields are qualified by the valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_upd_en && upd_taken) begin
            r_btb_tag[w_upd_low]    <= upd_pc[PC_W-1:IDX_W];
            r_btb_target[w_upd_low] <= upd_target;
            r_btb_cond[w_upd_low]   <= upd_is_cond;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module   : tb_branch_predictor
// Summary  : Directed self-checking bench; bimodal (PERF_W=2) and gshare DUTs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_valid       [2];
    logic [29:0] if_pc          [2];
    logic        pred_taken     [2];
    logic [29:0] pred_target    [2];
    logic [3:0]  pred_idx       [2];
    logic        upd_valid      [2];
    logic [29:0] upd_pc         [2];
    logic [3:0]  upd_idx        [2];
    logic        upd_is_cond    [2];
    logic        upd_taken      [2];
    logic [29:0] upd_target     [2];
    logic        upd_mispredict [2];
    logic [1:0]  cnt0;
    logic [31:0] cnt1;

    branch_predictor #(
        .PC_W(30), .IDX_W(4), .CTR_W(2), .GSHARE(0), .GHR_W(4), .PERF_W(2)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .if_valid(if_valid[0]), .if_pc(if_pc[0]),
        .pred_taken(pred_taken[0]), .pred_target(pred_target[0]), .pred_idx(pred_idx[0]),
        .upd_valid(upd_valid[0]), .upd_pc(upd_pc[0]), .upd_idx(upd_idx[0]),
        .upd_is_cond(upd_is_cond[0]), .upd_taken(upd_taken[0]), .upd_target(upd_target[0]),
        .upd_mispredict(upd_mispredict[0]), .mispred_cnt(cnt0)
    );

    branch_predictor #(
        .PC_W(30), .IDX_W(4), .CTR_W(2), .GSHARE(1), .GHR_W(4), .PERF_W(32)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .if_valid(if_valid[1]), .if_pc(if_pc[1]),
        .pred_taken(pred_taken[1]), .pred_target(pred_target[1]), .pred_idx(pred_idx[1]),
        .upd_valid(upd_valid[1]), .upd_pc(upd_pc[1]), .upd_idx(upd_idx[1]),
        .upd_is_cond(upd_is_cond[1]), .upd_taken(upd_taken[1]), .upd_target(upd_target[1]),
        .upd_mispredict(upd_mispredict[1]), .mispred_cnt(cnt1)
    );

    typedef struct {
        int          d;
        logic        taken;
        logic [29:0] target;
        logic [3:0]  idx;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_check();
        exp_t  e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".taken"},  {31'd0, pred_taken[e.d]}, {31'd0, e.taken});
        chk({t, ".target"}, {2'd0, pred_target[e.d]}, {2'd0, e.target});
        chk({t, ".idx"},    {28'd0, pred_idx[e.d]},   {28'd0, e.idx});
    endtask

    // Drive a lookup in the current cycle and check it #1 later (mid-low-phase).
    task automatic lookup_now(input int d, input logic [29:0] pc, input logic t,
                              input logic [29:0] tgt, input logic [3:0] idx, input string tag);
        exp_t e;
        if_valid[d] = 1'b1;
        if_pc[d]    = pc;
        e.d = d; e.taken = t; e.target = tgt; e.idx = idx;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        pop_check();
    endtask

    task automatic lookup(input int d, input logic [29:0] pc, input logic t,
                          input logic [29:0] tgt, input logic [3:0] idx, input string tag);
        @(negedge clk);
        lookup_now(d, pc, t, tgt, idx, tag);
    endtask

    task automatic set_upd(input int d, input logic v, input logic [29:0] pc, input logic [3:0] idx,
                           input logic cond, input logic tk, input logic [29:0] tgt, input logic mis);
        upd_valid[d]      = v;
        upd_pc[d]         = pc;
        upd_idx[d]        = idx;
        upd_is_cond[d]    = cond;
        upd_taken[d]      = tk;
        upd_target[d]     = tgt;
        upd_mispredict[d] = mis;
    endtask

    task automatic finish_upd(input int d);
        @(posedge clk);
        #1;
        upd_valid[d]      = 1'b0;
        upd_mispredict[d] = 1'b0;
    endtask

    task automatic do_upd(input int d, input logic v, input logic [29:0] pc, input logic [3:0] idx,
                          input logic cond, input logic tk, input logic [29:0] tgt, input logic mis);
        @(negedge clk);
        set_upd(d, v, pc, idx, cond, tk, tgt, mis);
        finish_upd(d);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_valid[i] = 1'b0;
            if_pc[i]    = '0;
            set_upd(i, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and miss behaviour
        lookup(0, 30'h100, 1'b0, 30'h101, 4'h0, "reset_lookup");
        chk("reset_cnt0", {30'd0, cnt0}, 32'd0);
        chk("reset_cnt1", cnt1, 32'd0);

        // Gshare: history 101 folds into the index
        lookup(1, 30'h104, 1'b0, 30'h105, 4'h4, "gs_ghr0");
        do_upd(1, 1'b1, 30'h200, 4'hA, 1'b1, 1'b1, 30'h300, 1'b0);
        do_upd(1, 1'b1, 30'h200, 4'hB, 1'b1, 1'b0, 30'h300, 1'b0);
        do_upd(1, 1'b1, 30'h104, 4'h1, 1'b1, 1'b1, 30'h080, 1'b0);
        lookup(1, 30'h104, 1'b1, 30'h080, 4'h1, "gs_ghr101");
        // Same-cycle update of the looked-up entry: lookup still sees the old counter
        @(negedge clk);
        set_upd(1, 1'b1, 30'h104, 4'h1, 1'b1, 1'b0, 30'h080, 1'b0);
        lookup_now(1, 30'h104, 1'b1, 30'h080, 4'h1, "gs_no_bypass");
        finish_upd(1);
        lookup(1, 30'h104, 1'b0, 30'h105, 4'hE, "gs_ghr1010");

        // Unconditional jump
        do_upd(0, 1'b1, 30'h100, 4'h0, 1'b0, 1'b1, 30'h2000, 1'b0);
        lookup(0, 30'h100, 1'b1, 30'h2000, 4'h0, "jmp_hit");
        lookup(0, 30'h110, 1'b0, 30'h111, 4'h0, "jmp_alias_miss");

        // Conditional branch counter walk
        do_upd(0, 1'b1, 30'h104, 4'h4, 1'b1, 1'b1, 30'h80, 1'b0);
        lookup(0, 30'h104, 1'b1, 30'h80, 4'h4, "br_taken1");
        repeat (2) do_upd(0, 1'b1, 30'h104, 4'h4, 1'b1, 1'b0, 30'h0, 1'b0);
        lookup(0, 30'h104, 1'b0, 30'h105, 4'h4, "br_nt2");
        repeat (4) do_upd(0, 1'b1, 30'h104, 4'h4, 1'b1, 1'b0, 30'h0, 1'b0);
        lookup(0, 30'h104, 1'b0, 30'h105, 4'h4, "br_floor");
        repeat (3) do_upd(0, 1'b1, 30'h104, 4'h4, 1'b1, 1'b1, 30'h80, 1'b0);
        lookup(0, 30'h104, 1'b1, 30'h80, 4'h4, "br_t3");
        do_upd(0, 1'b1, 30'h104, 4'h4, 1'b1, 1'b0, 30'h0, 1'b0);
        lookup(0, 30'h104, 1'b1, 30'h80, 4'h4, "br_from_max");
        do_upd(0, 1'b1, 30'h104, 4'h4, 1'b1, 1'b0, 30'h0, 1'b0);
        lookup(0, 30'h104, 1'b0, 30'h105, 4'h4, "br_weak_nt");

        // PC wrap and mispredict counter saturation
        lookup(0, 30'h3FFFFFFF, 1'b0, 30'h0, 4'hF, "pc_wrap");
        do_upd(0, 1'b1, 30'h3, 4'h3, 1'b0, 1'b0, 30'h0, 1'b1);
        chk("mis_cnt1", {30'd0, cnt0}, 32'd1);
        do_upd(0, 1'b1, 30'h3, 4'h3, 1'b0, 1'b0, 30'h0, 1'b1);
        chk("mis_cnt2", {30'd0, cnt0}, 32'd2);
        do_upd(0, 1'b1, 30'h3, 4'h3, 1'b0, 1'b0, 30'h0, 1'b1);
        chk("mis_cnt3", {30'd0, cnt0}, 32'd3);
        do_upd(0, 1'b1, 30'h3, 4'h3, 1'b0, 1'b0, 30'h0, 1'b1);
        chk("mis_sat", {30'd0, cnt0}, 32'd3);
        do_upd(1, 1'b0, 30'h3, 4'h3, 1'b0, 1'b0, 30'h0, 1'b1);
        chk("mis_novalid", cnt1, 32'd0);
        do_upd(1, 1'b1, 30'h3, 4'h3, 1'b0, 1'b0, 30'h0, 1'b1);
        chk("mis_valid", cnt1, 32'd1);

        // Mid-stream reset; the update presented alongside it is dropped
        lookup(0, 30'h100, 1'b1, 30'h2000, 4'h0, "pre_rst_hit");
        @(negedge clk);
        rst = 1'b1;
        set_upd(0, 1'b1, 30'h108, 4'h8, 1'b1, 1'b1, 30'h40, 1'b1);
        lookup_now(0, 30'h100, 1'b0, 30'h101, 4'h0, "in_rst");
        finish_upd(0);
        rst = 1'b0;
        lookup(0, 30'h100, 1'b0, 30'h101, 4'h0, "post_rst_jmp");
        lookup(0, 30'h104, 1'b0, 30'h105, 4'h4, "post_rst_br");
        lookup(0, 30'h108, 1'b0, 30'h109, 4'h8, "rst_upd_lost");
        chk("post_rst_cnt", {30'd0, cnt0}, 32'd0);
        do_upd(0, 1'b1, 30'h104, 4'h4, 1'b1, 1'b1, 30'h80, 1'b0);
        lookup(0, 30'h104, 1'b1, 30'h80, 4'h4, "post_rst_weak");

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
